// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: state encoding, opcodes and datapath mux select codes.
// The extra single-step states exist only when ISDU_SINGLE_STEP_EN is defined.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP,
        S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3, S_PAUSE1, S_PAUSE2
`ifdef ISDU_SINGLE_STEP_EN
        , S_SS1, S_SS2
`endif
    } state_t;

    function automatic logic is_mem_state(input state_t s);
        logic m;
        case (s)
            S_FETCH2, S_LDR2, S_STR3: m = 1'b1;
            default:                  m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/isdu_wait_ctr.sv
// Loadable 4-bit wait counter; done is high when the count reaches limit.
module isdu_wait_ctr (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    input  logic [3:0] limit,
    output logic       done
);

    logic [3:0] count_r;

    // count register: load has priority over increment
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (inc) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == limit);

endmodule

// File: rtl/lc3_isdu.sv
// LC-3 instruction sequence/decode unit: Moore control FSM with MEM_WAIT-cycle memory states.
// Optional macro ISDU_SINGLE_STEP_EN adds a Continue handshake after every instruction.
module lc3_isdu #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE
);
    import lc3_pkg::*;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);
`ifdef ISDU_SINGLE_STEP_EN
    localparam state_t S_RET = S_SS1;
`else
    localparam state_t S_RET = S_FETCH1;
`endif

    state_t state_r;
    state_t next_s;
    logic   mem_s;
    logic   done_s;
    logic   load_s;

    // The counter sits at zero outside memory states, so every entry starts a fresh count.
    assign mem_s  = is_mem_state(state_r);
    assign load_s = ~mem_s | done_s;

    isdu_wait_ctr u_wait (
        .Clk     (Clk),
        .Reset   (Reset),
        .load    (load_s),
        .load_val(4'd0),
        .inc     (mem_s),
        .limit   (WAIT_LAST),
        .done    (done_s)
    );

    // state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= S_HALTED;
        end else begin
            state_r <= next_s;
        end
    end

    // next-state and output decode
    always_comb begin
        next_s     = state_r;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_INC;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        case (state_r)
            S_HALTED: begin
                next_s = Run ? S_FETCH1 : S_HALTED;
            end
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = PCMUX_INC;
                LD_PC  = 1'b1;
                next_s = S_FETCH2;
            end
            S_FETCH2: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = 1'b1;
                next_s = done_s ? S_FETCH3 : S_FETCH2;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                next_s  = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD:  next_s = S_ADD;
                    OP_AND:  next_s = S_AND;
                    OP_NOT:  next_s = S_NOT;
                    OP_BR:   next_s = BEN ? S_BR_TAKEN : S_RET;
                    OP_JMP:  next_s = S_JMP;
                    OP_JSR:  next_s = S_JSR1;
                    OP_LDR:  next_s = S_LDR1;
                    OP_STR:  next_s = S_STR1;
                    OP_PSE:  next_s = S_PAUSE1;
                    default: next_s = S_RET;
                endcase
            end
            S_ADD, S_AND: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR_5;
                ALUK    = (state_r == S_AND) ? ALUK_AND : ALUK_ADD;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                next_s  = S_RET;
            end
            S_NOT: begin
                ALUK    = ALUK_NOT;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                next_s  = S_RET;
            end
            S_BR_TAKEN: begin
                ADDR2MUX = ADDR2_OFF9;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
                next_s   = S_RET;
            end
            S_JMP: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
                next_s   = S_RET;
            end
            S_JSR1: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
                next_s = S_JSR2;
            end
            S_JSR2: begin
                ADDR1MUX = ~IR_11;
                ADDR2MUX = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
                next_s   = S_RET;
            end
            S_LDR1, S_STR1: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_OFF6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                next_s     = (state_r == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR2: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = 1'b1;
                next_s = done_s ? S_LDR3 : S_LDR2;
            end
            S_LDR3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                next_s  = S_RET;
            end
            S_STR2: begin
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                next_s  = S_STR3;
            end
            S_STR3: begin
                Mem_WE = 1'b0;
                next_s = done_s ? S_RET : S_STR3;
            end
            S_PAUSE1: begin
                LD_LED = 1'b1;
                next_s = Continue ? S_PAUSE2 : S_PAUSE1;
            end
            S_PAUSE2: begin
                next_s = Continue ? S_PAUSE2 : S_FETCH1;
            end
`ifdef ISDU_SINGLE_STEP_EN
            S_SS1: begin
                next_s = Continue ? S_SS2 : S_SS1;
            end
            S_SS2: begin
                next_s = Continue ? S_SS2 : S_FETCH1;
            end
`endif
            default: begin
                next_s = S_HALTED;
            end
        endcase
    end

endmodule

// File: doc/lc3_isdu.md
Name: lc3_isdu

Overview:
- Instruction-sequence/decode unit (control FSM) for the LC-3 datapath.
- Sits directly upstream of the datapath mux/gate stage and drives every mux select, bus gate, register load and memory strobe.
- Sequences the fetch, decode and execute states for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PSE.
- Inserts a parameterised number of memory wait cycles on every SRAM access.

Parameters:
- MEM_WAIT, 2, cycles each memory read/write state is held (1..15). The state exits after MEM_WAIT cycles.

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Run  in  1  start pulse; leaves HALTED
- Continue  in  1  resume from PSE pause
- Opcode  in  4  IR[15:12]
- IR_5  in  1  immediate flag for ADD/AND
- IR_11  in  1  JSR (1) vs JSRR (0)
- BEN  in  1  branch-enable register value
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle
- PCMUX  out  2  00=PC+1, 01=BUS, 10=ADDER
- DRMUX  out  1  0=IR[11:9], 1=R7
- SR1MUX  out  1  0=IR[11:9], 1=IR[8:6]
- SR2MUX  out  1  0=SR2 register, 1=SEXT(imm5)
- ADDR1MUX  out  1  0=PC, 1=SR1
- ADDR2MUX  out  2  00=0, 01=off6, 10=off9, 11=off11
- ALUK  out  2  00=ADD, 01=AND, 10=NOT, 11=PASS A
- MIO_EN  out  1  MDR source select: 0=BUS, 1=memory
- Mem_OE  out  1  active-low read strobe
- Mem_WE  out  1  active-low write strobe

Behaviour:
- Moore FSM. All outputs are decoded combinationally from the state register only.
- Outputs not listed for a state are 0, except Mem_OE/Mem_WE, which default to 1.
- Reset (async): state=HALTED, wait counter=0, outputs at defaults. Reset mid-instruction aborts the instruction with no further loads.

States and transitions:
- HALTED: goes to FETCH1 when Run=1.
- FETCH1: GatePC, LD_MAR, PCMUX=00, LD_PC.
- FETCH2: Mem_OE=0, MIO_EN=1, LD_MDR. Held MEM_WAIT cycles.
- FETCH3: GateMDR, LD_IR.
- DECODE: LD_BEN, then branch on Opcode.
- ADD (0001) / AND (0101): SR1MUX=1, SR2MUX=IR_5, ALUK=00/01, GateALU, LD_REG, LD_CC.
- NOT (1001): ALUK=10, GateALU, LD_REG, LD_CC.
- BR (0000):
  - BEN=1 goes to BR_TAKEN: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC.
  - BEN=0 goes to FETCH1.
- JMP (1100): SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC.
- JSR (0100):
  - JSR1: GatePC, DRMUX=1, LD_REG.
  - JSR2, IR_11=1: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC.
  - JSR2, IR_11=0: ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC.
- LDR (0110):
  - LDR1: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR.
  - LDR2: read, held MEM_WAIT cycles.
  - LDR3: GateMDR, LD_REG, LD_CC.
- STR (0111):
  - STR1: as LDR1.
  - STR2: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR.
  - STR3: Mem_WE=0, held MEM_WAIT cycles.
- PSE (1101):
  - PAUSE1: LD_LED; stays until Continue=1.
  - PAUSE2: stays until Continue=0, then goes to FETCH1.
- Unused opcodes go to FETCH1 as a NOP.
- Every execute state not noted above returns to FETCH1.

Wait counter:
- 4-bit counter, cleared on entry to a memory state.
- Increments each cycle in that state; exits when count==MEM_WAIT-1.
- Mem_OE/Mem_WE are held low continuously through the wait.

Cycle counts:
- Instruction latency with MEM_WAIT=2: ADD is 6 cycles (FETCH1, FETCH2 x2, FETCH3, DECODE, ADD).

Invariants:
- Run is ignored outside HALTED.
- Continue is only sampled in PAUSE states.
- Mem_OE and Mem_WE are never both low.

Optional Feature:
- Macro: ISDU_SINGLE_STEP_EN.
- Defined: every return to FETCH1 from an execute state first passes through PAUSE1/PAUSE2 with LD_LED=0, requiring a Continue high-then-low handshake per instruction.
- Undefined: execute states go straight to FETCH1 and the extra states are not synthesised.

Decomposition:
- Shared package lc3_pkg:
  - state_t enum
  - opcode localparams (OP_ADD=4'b0001 etc.)
  - PCMUX/ADDR2MUX/ALUK select encodings, matching the datapath mux encodings exactly.
- One sub-module, isdu_wait_ctr: loadable 4-bit counter with a done flag, Clk/Reset async.

Test Plan:
- Reset=1 mid-FETCH2 -> next cycle HALTED, Mem_OE=1, every LD_*=0; Run=1 then FETCH1 with GatePC=1, LD_MAR=1, PCMUX=00.
- Run, Opcode=0001, IR_5=1, MEM_WAIT=2 -> Mem_OE low exactly 2 cycles; cycle 6 shows GateALU=1, SR2MUX=1, ALUK=00, LD_REG=1, LD_CC=1; cycle 7 is FETCH1.
- Opcode=0000 with BEN=0 -> DECODE then FETCH1, LD_PC never asserted with PCMUX=10; with BEN=1 -> one cycle PCMUX=10, ADDR2MUX=10, LD_PC=1.
- Opcode=0111, MEM_WAIT=3 -> STR2 has ALUK=11, MIO_EN=0, LD_MDR=1; Mem_WE low exactly 3 cycles; Mem_OE=1 throughout.
- Opcode=1101, Continue held 0 for 10 cycles -> remains PAUSE1 with LD_LED=1; Continue 1 then 0 -> FETCH1.
- ISDU_SINGLE_STEP_EN defined, Opcode=1001 -> after NOT state enters PAUSE1 with LD_LED=0; no FETCH1 until the Continue handshake completes.
